// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit holding the HI/LO architectural
// registers. MULT/MULTU/DIV/DIVU results are computed in the start cycle
// and parked in a pending register. They are committed to HI/LO after a
// fixed latency. While they wait, busy is asserted so the hazard unit can
// stall dependent MD instructions.
//
// Handshake: start is a one-cycle request. It is accepted only in IDLE.
// busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles after the start
// cycle. The first cycle with busy low shows the new HI/LO. start is never
// back-pressured here; the hazard unit keeps it low while busy is high.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        md_we,
  input  logic [31:0] E_V1_f,
  input  logic [31:0] E_V2_f,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic [63:0] pend_q;
  logic        pend_ok_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;

  // Datapath signals for the single-cycle result computation.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_a, div_b, div_b_safe;
  logic [31:0] uq, ur, quo, rem;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [63:0] result_d;
  logic        result_ok_d;

  // Result of the requested op. md_op[0] selects unsigned and md_op[1] selects divide.
  // Signed divide is done on magnitudes and the signs are fixed afterwards.
  // This gives 0x80000000 / -1 = 0x80000000 with remainder 0, and does not trap.
  always_comb begin
    a_neg      = E_V1_f[31];
    b_neg      = E_V2_f[31];
    a_mag      = a_neg ? (32'd0 - E_V1_f) : E_V1_f;
    b_mag      = b_neg ? (32'd0 - E_V2_f) : E_V2_f;
    div_a      = md_op[0] ? E_V1_f : a_mag;
    div_b      = md_op[0] ? E_V2_f : b_mag;
    div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
    uq         = div_a / div_b_safe;
    ur         = div_a % div_b_safe;
    quo        = (!md_op[0] && (a_neg ^ b_neg)) ? (32'd0 - uq) : uq;
    rem        = (!md_op[0] && a_neg) ? (32'd0 - ur) : ur;
    a_sx       = {{32{E_V1_f[31]}}, E_V1_f};
    b_sx       = {{32{E_V2_f[31]}}, E_V2_f};
    prod_s     = a_sx * b_sx;
    prod_u     = {32'd0, E_V1_f} * {32'd0, E_V2_f};
    result_d   = md_op[1] ? {rem, quo} : (md_op[0] ? prod_u : prod_s);
    // A divide by zero still runs its full latency but leaves HI/LO untouched.
    result_ok_d = !(md_op[1] && (E_V2_f == 32'd0));
  end

  // IDLE/RUN sequencer. HI/LO writes, latency counter and busy are all registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= 4'd0;
      pend_q    <= 64'd0;
      pend_ok_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !md_op[2]) begin
            // start takes priority over a simultaneous (illegal) md_we.
            pend_q    <= result_d;
            pend_ok_q <= result_ok_d;
            count_q   <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end else if (md_we && (md_op[2:1] == 2'b10)) begin
            if (md_op[0]) lo_q <= E_V1_f;
            else          hi_q <= E_V1_f;
          end
        end
        S_RUN: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            if (pend_ok_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign MDU_out = (md_op == 3'd6) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Testbench for mdu_unit: scenario tasks plus randomized ops checked
// against an arithmetic reference model of HI/LO.
module tb_mdu_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset, start, md_we;
  logic [2:0]  md_op;
  logic [31:0] v1, v2;
  logic        busy;
  logic [31:0] hi, lo, mdu_out;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_we(md_we),
    .E_V1_f(v1), .E_V2_f(v2), .busy(busy), .HI(hi), .LO(lo), .MDU_out(mdu_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and scoreboard.
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic [63:0] exp_q[$];

  // The hazard unit never issues start while busy. Flag it if the bench ever does.
  always @(negedge clk) begin
    if (start === 1'b1 && busy === 1'b1) begin
      n_fail++;
      $display("FAIL start_while_busy: start=%b busy=%b required busy=0", start, busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Expected {HI,LO} after an op, from the instruction-set arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] h, l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {h, l};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = (b == 32'd0) ? {h, l} : {a % b, a / b};
    endcase
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one op, check that busy is high for the full latency with committed HI/LO
  // held, then check that the new HI/LO appear. Call and return at posedge+1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] e;
    n = op[1] ? DIV_N : MULT_N;
    exp_q.push_back(model(op, a, b, exp_hi, exp_lo));
    start = 1'b1; md_op = op; v1 = a; v2 = b;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_in_start_cycle: got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd6; v1 = $urandom; v2 = $urandom;
    for (int i = 0; i < n; i++) begin
      #1;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_len op=%0d cyc=%0d: got %b want 1", op, i, busy); end
      n_checks++;
      if ({hi, lo} !== {exp_hi, exp_lo}) begin
        n_fail++; $display("FAIL hold_during_busy op=%0d cyc=%0d: got %h_%h want %h_%h", op, i, hi, lo, exp_hi, exp_lo);
      end
      n_checks++;
      if (mdu_out !== exp_hi) begin n_fail++; $display("FAIL mfhi_committed cyc=%0d: got %h want %h", i, mdu_out, exp_hi); end
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_drop op=%0d: got %b want 0", op, busy); end
    n_checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      n_fail++; $display("FAIL result op=%0d a=%h b=%h: got %h_%h want %h_%h", op, a, b, hi, lo, exp_hi, exp_lo);
    end
  endtask

  // MTHI (sel_hi=1) or MTLO in IDLE. Called and returns at posedge+1.
  task automatic mt_write(input logic sel_hi, input logic [31:0] data);
    md_we = 1'b1; md_op = sel_hi ? 3'd4 : 3'd5; v1 = data;
    @(posedge clk); #1;
    md_we = 1'b0;
    if (sel_hi) exp_hi = data; else exp_lo = data;
    n_checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      n_fail++; $display("FAIL mt_write: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #3;
    n_checks++;
    if ({busy, hi, lo, mdu_out} !== 97'd0) begin
      n_fail++; $display("FAIL reset_state: busy=%b hi=%h lo=%h out=%h want all 0", busy, hi, lo, mdu_out);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    run_op(3'd0, 32'hFFFFFFFE, 32'h00000003);
    n_checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFA}) begin n_fail++; $display("FAIL mult_vec: got %h_%h want ffffffff_fffffffa", hi, lo); end
    run_op(3'd1, 32'hFFFFFFFE, 32'h00000003);
    n_checks++;
    if ({hi, lo} !== {32'h00000002, 32'hFFFFFFFA}) begin n_fail++; $display("FAIL multu_vec: got %h_%h want 00000002_fffffffa", hi, lo); end
  endtask

  task automatic test_div;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    n_checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL div_vec: got %h_%h want ffffffff_fffffffd", hi, lo); end
    run_op(3'd3, 32'd7, 32'd2);
    n_checks++;
    if ({hi, lo} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL divu_vec: got %h_%h want 00000001_00000003", hi, lo); end
  endtask

  task automatic test_div_edge;
    mt_write(1'b1, 32'h11);
    mt_write(1'b0, 32'h22);
    run_op(3'd2, 32'd1234, 32'd0);
    n_checks++;
    if ({hi, lo} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL div_by_zero: got %h_%h want 00000011_00000022", hi, lo); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    n_checks++;
    if ({hi, lo} !== {32'h0, 32'h80000000}) begin n_fail++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_mt_busy;
    int waited;
    start = 1'b1; md_op = 3'd3; v1 = 32'd9; v2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    md_we = 1'b1; md_op = 3'd5; v1 = 32'h5;
    @(posedge clk); #1;
    md_we = 1'b0; md_op = 3'd7;
    n_checks++;
    if (lo !== exp_lo) begin n_fail++; $display("FAIL mtlo_during_busy: got %h want %h", lo, exp_lo); end
    waited = 0;
    while (busy === 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_wait_bound: busy=%b after %0d cycles", busy, waited); end
    n_checks++;
    if (lo !== exp_lo) begin n_fail++; $display("FAIL lo_after_busy_mt: got %h want %h", lo, exp_lo); end
    mt_write(1'b0, 32'h5);
    md_op = 3'd7; #1;
    n_checks++;
    if (mdu_out !== 32'h5) begin n_fail++; $display("FAIL mflo_out: got %h want 00000005", mdu_out); end
    md_op = 3'd6; #1;
    n_checks++;
    if (mdu_out !== exp_hi) begin n_fail++; $display("FAIL mfhi_out: got %h want %h", mdu_out, exp_hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    run_op(3'd0, 32'h12345678, 32'hFEDCBA98);
    run_op(3'd2, 32'h7FFFFFFF, 32'hFFFFFFF3);
  endtask

  task automatic test_reset_mid_run;
    mt_write(1'b1, 32'hAA);
    mt_write(1'b0, 32'hBB);
    start = 1'b1; md_op = 3'd2; v1 = 32'd100; v2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    n_checks++;
    if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL async_reset_mid_run: busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < DIV_N + 2; i++) begin
      n_checks++;
      if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL idle_after_reset cyc=%0d: busy=%b hi=%h lo=%h", i, busy, hi, lo); end
      @(posedge clk); #1;
    end
    run_op(3'd3, 32'd100, 32'd7);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(op, a, b);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_we = 1'b0; md_op = 3'd0; v1 = 32'd0; v2 = 32'd0;
    test_reset;
    test_reset_mid_run;
    test_mult;
    test_div;
    test_div_edge;
    test_mt_busy;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
